// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_bank data memory.
//   dmem_state_e  : sweep/ready state encoding used by dmem_bank
//   DMEM_*        : default width/depth constants for the CPU data path
//   byte_merge()  : byte-enable merge of a new word into an old word
// Optional build macro used by this slice: DMEM_WRITE_FIRST_EN (see dmem_bank).
package dmem_pkg;

  typedef enum logic {
    DMEM_CLEAR,
    DMEM_READY
  } dmem_state_e;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DEPTH  = 256;

  // byte_merge works on the widest supported word; callers zero-extend
  // their operands and truncate the result back to DATA_W.
  localparam int DMEM_MERGE_W  = 256;
  localparam int DMEM_MERGE_BE = DMEM_MERGE_W / 8;

  function automatic logic [DMEM_MERGE_W-1:0] byte_merge(
    input logic [DMEM_MERGE_W-1:0]  old_word,
    input logic [DMEM_MERGE_W-1:0]  new_word,
    input logic [DMEM_MERGE_BE-1:0] be
  );
    logic [DMEM_MERGE_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < DMEM_MERGE_BE; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: plain DEPTH x DATA_W storage.
//   clk, reset : clock and synchronous active-high reset (read register only)
//   addr       : shared word address for the write and read ports
//   we, be     : write enable and per-byte enables
//   wdata      : write data
//   re         : load the read register from mem[addr]
//   rzero      : load the read register with zero (takes priority over re)
//   rdata      : registered read data; holds when neither re nor rzero
// A read and write to the same address on one edge return the old word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PTR_W-1:0]  addr,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rzero,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset; dmem_bank clears it with a sweep instead.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rzero) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_bank.sv
// dmem_bank: parametrised synchronous data memory with valid/ready requests.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only after the clear sweep)
//   req_write, req_addr : 1 = write, word address
//   req_wdata, req_be   : write data and byte enables (bit i = byte i)
//   rsp_valid           : one-cycle pulse on the edge after an accepted request
//   rsp_rdata           : read data (read-first for writes by default)
//   rsp_err             : address >= DEPTH, qualified by rsp_valid
//   busy                : clear sweep in progress
// Build macro DMEM_WRITE_FIRST_EN: accepted in-range writes return the
// post-merge word instead of the old word.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  dmem_state_e       state;
  logic [PTR_W-1:0]  clear_ptr;
  logic              out_of_range;
  logic              accept;

  logic [PTR_W-1:0]  arr_addr;
  logic              arr_we;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_wdata;
  logic              arr_re;
  logic              arr_rzero;
  logic [DATA_W-1:0] arr_rdata;

  // One extra bit keeps the compare exact even when DEPTH == 2**ADDR_W.
  assign out_of_range = (CMP_W'(req_addr) >= CMP_W'(DEPTH));

  // A request coinciding with reset is dropped so no write or response leaks.
  assign accept = req_valid && req_ready && (state == DMEM_READY) && !reset;

  // The sweep owns the array port in CLEAR; requests own it in READY.
  always_comb begin
    arr_addr  = req_addr[PTR_W-1:0];
    arr_we    = 1'b0;
    arr_be    = '0;
    arr_wdata = '0;
    arr_re    = 1'b0;
    arr_rzero = 1'b0;
    if (state == DMEM_CLEAR && !reset) begin
      arr_addr = clear_ptr;
      arr_we   = 1'b1;
      arr_be   = '1;
    end else if (accept) begin
      arr_we    = req_write && !out_of_range;
      arr_be    = req_be;
      arr_wdata = req_wdata;
      arr_re    = !out_of_range;
      arr_rzero = out_of_range;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .BE_W   (BE_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .addr  (arr_addr),
    .we    (arr_we),
    .be    (arr_be),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rzero (arr_rzero),
    .rdata (arr_rdata)
  );

  // Sweep state machine plus the registered handshake/response flags.
  // clear_ptr stops at LAST_PTR rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DMEM_CLEAR;
      clear_ptr <= '0;
      busy      <= 1'b1;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        DMEM_CLEAR: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (clear_ptr == LAST_PTR) begin
            state     <= DMEM_READY;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            clear_ptr <= clear_ptr + 1'b1;
          end
        end
        DMEM_READY: begin
          rsp_valid <= accept;
          rsp_err   <= accept && out_of_range;
        end
        default: begin
          state <= DMEM_CLEAR;
        end
      endcase
    end
  end

`ifdef DMEM_WRITE_FIRST_EN
  logic              wf_q;
  logic [DATA_W-1:0] wf_data_q;
  logic [BE_W-1:0]   wf_be_q;

  // Remember the write that produced the current response so the old word
  // coming out of the array can be merged into the post-write value.
  always_ff @(posedge clk) begin
    if (reset) begin
      wf_q      <= 1'b0;
      wf_data_q <= '0;
      wf_be_q   <= '0;
    end else if (accept) begin
      wf_q      <= req_write && !out_of_range;
      wf_data_q <= req_wdata;
      wf_be_q   <= req_be;
    end
  end

  assign rsp_rdata = wf_q ? DATA_W'(byte_merge(DMEM_MERGE_W'(arr_rdata),
                                               DMEM_MERGE_W'(wf_data_q),
                                               DMEM_MERGE_BE'(wf_be_q)))
                          : arr_rdata;
`else
  assign rsp_rdata = arr_rdata;
`endif

endmodule

// File: tb/tb_dmem_bank.sv
// tb_dmem_bank: self-checking bench for dmem_bank (default 32x256, ADDR_W 16).
// Directed scenarios plus a randomized stream compared against a word-array
// reference model. Honours DMEM_WRITE_FIRST_EN when it is defined.
module tb_dmem_bank;

  localparam int DEPTH = 256;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int passes = 0;

  // Reference model: the memory as seen by software, plus what the next
  // response should look like.
  logic [31:0] model_mem [DEPTH];
  logic        model_ready;
  logic        exp_valid;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata;

  dmem_bank #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    last_rdata = 32'h0;
  endfunction

  // Expected response for one cycle of request inputs.
  function automatic void model_step(input logic v, input logic w, input logic [15:0] a,
                                     input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask;
    logic [31:0] oldw;
    logic [31:0] neww;
    if (!v || !model_ready) begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = last_rdata;
    end else if (int'(a) >= DEPTH) begin
      exp_valid = 1'b1;
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
    end else begin
      mask = 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
      oldw = model_mem[a];
      neww = (oldw & ~mask) | (d & mask);
      exp_valid = 1'b1;
      exp_err   = 1'b0;
      exp_rdata = oldw;
`ifdef DMEM_WRITE_FIRST_EN
      if (w) exp_rdata = neww;
`endif
      if (w) model_mem[a] = neww;
    end
    last_rdata = exp_rdata;
  endfunction

  // Drives one cycle of request inputs; the response is observable on return.
  task automatic drive(input logic v, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    model_step(v, w, a, d, be);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts edges until req_ready rises, bounded.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (req_ready !== 1'b1 && edges < 1000) begin
      @(posedge clk);
      #1;
      edges++;
    end
    model_ready = (req_ready === 1'b1);
  endtask

  task automatic test_reset();
    int edges;
    int busy_bad;
    reset = 1'b1;
    model_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b expected 1", busy); else passes++;
    checks++; if (req_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) $display("[TB] FAIL reset_rsp: got valid %b err %b expected 0 0", rsp_valid, rsp_err); else passes++;
    checks++; if (rsp_rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 00000000", rsp_rdata); else passes++;
    reset = 1'b0;
    edges = 0;
    busy_bad = 0;
    // Requests offered during the sweep must be ignored.
    while (req_ready !== 1'b1 && edges < 1000) begin
      if (busy !== 1'b1 || rsp_valid !== 1'b0) busy_bad++;
      req_valid = 1'($urandom);
      req_write = 1'b1;
      req_addr  = 16'($urandom_range(0, 255));
      req_wdata = $urandom;
      req_be    = 4'hF;
      @(posedge clk);
      #1;
      edges++;
    end
    req_valid = 1'b0;
    model_ready = (req_ready === 1'b1);
    checks++; if (edges != 256) $display("[TB] FAIL sweep_len: got %0d edges expected 256", edges); else passes++;
    checks++; if (busy_bad != 0) $display("[TB] FAIL sweep_busy: got %0d bad cycles expected 0", busy_bad); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL ready_busy: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_clear_contents();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 16'(i), 32'h0, 4'h0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
        $display("[TB] FAIL clear_rd[%0d]: got v%b e%b %h expected v1 e0 00000000", i, rsp_valid, rsp_err, rsp_rdata);
      else passes++;
    end
  endtask

  task automatic test_full_write();
    logic [31:0] wr_exp;
`ifdef DMEM_WRITE_FIRST_EN
    wr_exp = 32'hDEADBEEF;
`else
    wr_exp = 32'h0;
`endif
    drive(1'b1, 1'b1, 16'd5, 32'hDEADBEEF, 4'hF);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== wr_exp) $display("[TB] FAIL wr5_rsp: got v%b %h expected v1 %h", rsp_valid, rsp_rdata, wr_exp); else passes++;
    drive(1'b1, 1'b0, 16'd5, 32'h0, 4'h0);
    checks++; if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) $display("[TB] FAIL rd5: got %h e%b expected deadbeef e0", rsp_rdata, rsp_err); else passes++;
  endtask

  task automatic test_byte_enable();
    logic [31:0] wr_exp;
`ifdef DMEM_WRITE_FIRST_EN
    wr_exp = 32'hDE22BE44;
`else
    wr_exp = 32'hDEADBEEF;
`endif
    drive(1'b1, 1'b1, 16'd5, 32'h11223344, 4'b0101);
    checks++; if (rsp_rdata !== wr_exp) $display("[TB] FAIL be_wr_rsp: got %h expected %h", rsp_rdata, wr_exp); else passes++;
    drive(1'b1, 1'b0, 16'd5, 32'h0, 4'h0);
    checks++; if (rsp_rdata !== 32'hDE22BE44) $display("[TB] FAIL be_rd: got %h expected de22be44", rsp_rdata); else passes++;
    drive(1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDE22BE44) $display("[TB] FAIL idle_hold: got v%b e%b %h expected v0 e0 de22be44", rsp_valid, rsp_err, rsp_rdata); else passes++;
    drive(1'b1, 1'b1, 16'd5, 32'hFFFFFFFF, 4'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44) $display("[TB] FAIL be0_rsp: got v%b %h expected v1 de22be44", rsp_valid, rsp_rdata); else passes++;
    drive(1'b1, 1'b0, 16'd5, 32'h0, 4'h0);
    checks++; if (rsp_rdata !== 32'hDE22BE44) $display("[TB] FAIL be0_rd: got %h expected de22be44", rsp_rdata); else passes++;
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 16'd44, 32'h5A5A5A5A, 4'hF);
    drive(1'b1, 1'b0, 16'd300, 32'h0, 4'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("[TB] FAIL oor_rd: got v%b e%b %h expected v1 e1 00000000", rsp_valid, rsp_err, rsp_rdata); else passes++;
    drive(1'b1, 1'b1, 16'd300, 32'h12345678, 4'hF);
    checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("[TB] FAIL oor_wr: got e%b %h expected e1 00000000", rsp_err, rsp_rdata); else passes++;
    drive(1'b1, 1'b0, 16'd44, 32'h0, 4'h0);
    checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h5A5A5A5A) $display("[TB] FAIL oor_alias: got e%b %h expected e0 5a5a5a5a", rsp_err, rsp_rdata); else passes++;
    drive(1'b1, 1'b0, 16'd255, 32'h0, 4'h0);
    checks++; if (rsp_err !== 1'b0) $display("[TB] FAIL edge_255: got e%b expected e0", rsp_err); else passes++;
    drive(1'b1, 1'b0, 16'd256, 32'h0, 4'h0);
    checks++; if (rsp_err !== 1'b1) $display("[TB] FAIL edge_256: got e%b expected e1", rsp_err); else passes++;
    drive(1'b1, 1'b0, 16'hFFFF, 32'h0, 4'h0);
    checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("[TB] FAIL edge_ffff: got e%b %h expected e1 00000000", rsp_err, rsp_rdata); else passes++;
    drive(1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
    checks++; if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) $display("[TB] FAIL oor_idle: got v%b e%b expected v0 e0", rsp_valid, rsp_err); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    int edges;
    want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 16'(i + 1), want[i], 4'hF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'(i + 1), 32'h0, 4'h0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== want[i])
        $display("[TB] FAIL stream_rd[%0d]: got v%b %h expected v1 %h", i, rsp_valid, rsp_rdata, want[i]);
      else passes++;
    end
    // Reset arrives together with the next request: nothing may come out.
    reset = 1'b1;
    model_ready = 1'b0;
    model_clear();
    drive(1'b1, 1'b0, 16'd2, 32'h0, 4'h0);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL drop_rsp: got v%b rdy%b busy%b expected v0 rdy0 busy1", rsp_valid, req_ready, busy); else passes++;
    reset = 1'b0;
    wait_ready(edges);
    checks++; if (edges != 256) $display("[TB] FAIL resweep_len: got %0d edges expected 256", edges); else passes++;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 16'(i), 32'h0, 4'h0);
      checks++;
      if (rsp_rdata !== 32'h0) $display("[TB] FAIL recleared[%0d]: got %h expected 00000000", i, rsp_rdata);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int edges;
    drive(1'b1, 1'b1, 16'd7, 32'hCAFEF00D, 4'hF);
    reset = 1'b1;
    model_ready = 1'b0;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) $display("[TB] FAIL mid_sweep: got busy%b rdy%b expected busy1 rdy0", busy, req_ready); else passes++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready(edges);
    checks++; if (edges != 256) $display("[TB] FAIL restart_len: got %0d edges expected 256", edges); else passes++;
    drive(1'b1, 1'b0, 16'd7, 32'h0, 4'h0);
    checks++; if (rsp_rdata !== 32'h0) $display("[TB] FAIL restart_clr: got %h expected 00000000", rsp_rdata); else passes++;
  endtask

  task automatic test_random();
    logic        v;
    logic        w;
    logic [15:0] a;
    int          errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      w = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a = 16'($urandom_range(256, 65535));
        1:       a = 16'($urandom_range(0, 255));
        default: a = 16'($urandom_range(0, 15));
      endcase
      drive(v, w, a, $urandom, 4'($urandom));
      checks++;
      if (rsp_valid !== exp_valid || rsp_err !== exp_err || rsp_rdata !== exp_rdata || req_ready !== 1'b1) begin
        errs++;
        if (errs <= 10)
          $display("[TB] FAIL rand[%0d]: got v%b e%b %h rdy%b expected v%b e%b %h rdy1",
                   n, rsp_valid, rsp_err, rsp_rdata, req_ready, exp_valid, exp_err, exp_rdata);
      end else passes++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_be      = '0;
    model_ready = 1'b0;
    exp_valid   = 1'b0;
    exp_err     = 1'b0;
    exp_rdata   = '0;
    last_rdata  = '0;
    test_reset();
    test_clear_contents();
    test_full_write();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_sweep();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
